// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - shared state encoding and control-field constants for mc_control_fsm
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11,
    S_HALT   = 4'd12,
    S_BNEST  = 4'd13
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_ADDI  = 2'b11;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_control_fsm.sv
// rtl/mc_control_fsm.sv - multi-cycle MIPS control FSM with memory wait timeout and illegal-opcode trap
// Optional bne support via BNE_EN (adds state BNEST and port pc_write_cond_ne).
import mc_ctrl_pkg::*;

module mc_control_fsm #(
  parameter int OPCODE_W    = 6,
  parameter int ALUOP_W     = 2,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                pc_write_cond,
`ifdef BNE_EN
  output logic                pc_write_cond_ne,
`endif
  output logic                i_or_d,
  output logic                mem_read,
  output logic                mem_write,
  output logic                ir_write,
  output logic                reg_dst,
  output logic                mem_to_reg,
  output logic                reg_write,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [ALUOP_W-1:0]  alu_op,
  output logic [1:0]          pc_source,
  output logic                instr_done,
  output logic                fault,
  output logic [3:0]          state
);

  localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_SAT  = {CNT_W{1'b1}};

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wait_st;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    wait_st       = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
`ifdef BNE_EN
    pc_write_cond_ne = 1'b0;
`endif
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_B;
    alu_op        = ALUOP_W'(ALUOP_ADD);
    pc_source     = PCSRC_ALU;
    instr_done    = 1'b0;
    fault         = 1'b0;

    case (state_q)
      S_FETCH: begin
        wait_st   = 1'b1;
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = SRCB_IMM_SH2;
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
`ifdef BNE_EN
          OP_BNE:       state_d = S_BNEST;
`endif
          default:      state_d = S_HALT;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        // IR still holds the opcode, so lw/sw can be split here
        if (opcode == OP_LW)      state_d = S_MEMRD;
        else if (opcode == OP_SW) state_d = S_MEMWR;
        else                      state_d = S_HALT;
      end
      S_MEMRD: begin
        wait_st  = 1'b1;
        i_or_d   = 1'b1;
        mem_read = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        wait_st    = 1'b1;
        i_or_d     = 1'b1;
        mem_write  = 1'b1;
        instr_done = mem_ready;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_W'(ALUOP_FUNCT);
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALUOP_W'(ALUOP_SUB);
        pc_write_cond = 1'b1;
        pc_source     = PCSRC_ALUOUT;
        instr_done    = 1'b1;
        state_d       = S_FETCH;
      end
`ifdef BNE_EN
      S_BNEST: begin
        alu_src_a        = 1'b1;
        alu_op           = ALUOP_W'(ALUOP_SUB);
        pc_write_cond    = 1'b1;
        pc_write_cond_ne = 1'b1;
        pc_source        = PCSRC_ALUOUT;
        instr_done       = 1'b1;
        state_d          = S_FETCH;
      end
`endif
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_W'(ALUOP_ADDI);
        state_d   = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_JUMP: begin
        pc_write   = 1'b1;
        pc_source  = PCSRC_JUMP;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      default: begin
        fault   = 1'b1;
        state_d = S_HALT;
      end
    endcase

    // A ready on the final allowed cycle still completes the access
    if ((MEM_TIMEOUT > 0) && wait_st && !mem_ready && (cnt_q == TO_LIMIT))
      state_d = S_HALT;

    if (mem_ready || !wait_st || (state_d != state_q)) cnt_d = '0;
    else if (cnt_q != CNT_SAT)                         cnt_d = cnt_q + 1'b1;
    else                                               cnt_d = cnt_q;
  end

  assign state = state_q;

endmodule
